// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timebase: debounced start/stop/clear control, prescaled cascaded BCD counter, packed digits out.
// Optional lap-hold display freeze is built only when the macro LAP_HOLD_EN is defined.

module stopwatch_btn_deb #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    logic          sync0_q;
    logic          sync1_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync1_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_MAX) begin
            level_d = sync1_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer, debounce state and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q      <= 1'b0;
            sync1_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync0_q      <= btn_i;
            sync1_q      <= sync0_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_prev_q;
endmodule

module stopwatch_bcd_core #(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int NDIG       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_ss,
    input  logic              btn_clr,
    input  logic              btn_lap,
    output logic [4*NDIG-1:0] bcd,
    output logic              running,
    output logic              tick,
    output logic              ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            state_q;
    logic              running_q;
    logic              tick_q;
    logic              ovf_q;
    logic              ovf_d;
    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [4*NDIG-1:0] cnt_q;
    logic [4*NDIG-1:0] cnt_d;
    logic              wrap_s;
    logic              ss_press_s;
    logic              clr_press_s;
    logic              clr_accept_s;

    stopwatch_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_ss),
        .press_o(ss_press_s)
    );

    stopwatch_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_clr),
        .press_o(clr_press_s)
    );

    // Clear is refused while running; outside RUN it beats a simultaneous start/stop.
    assign clr_accept_s = clr_press_s && (state_q != S_RUN);

    // Start/pause/clear state machine with registered running flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr_accept_s) begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                    end else if (ss_press_s) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end else begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (ss_press_s) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end else begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (clr_accept_s) begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                    end else if (ss_press_s) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end else begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler and digit cascade; prescaler holds outside RUN so resume keeps the fraction.
    always_comb begin
        logic carry_v;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wrap_s  = 1'b0;
        carry_v = 1'b0;
        if (clr_accept_s) begin
            presc_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                wrap_s  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            carry_v = wrap_s;
            for (int i = 0; i < NDIG; i++) begin
                if (!carry_v) begin
                    cnt_d[4*i +: 4] = cnt_q[4*i +: 4];
                end else if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_d[4*i +: 4] = 4'd0;
                end else begin
                    cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry_v         = 1'b0;
                end
            end
            ovf_d = ovf_q | carry_v;
        end else begin
            presc_d = presc_q;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q;
        end
    end

    // Counter, prescaler, overflow and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tick_q  <= wrap_s;
        end
    end

`ifdef LAP_HOLD_EN
    logic              lap_press_s;
    logic              lap_accept_s;
    logic              hold_q;
    logic              hold_d;
    logic [4*NDIG-1:0] bcd_q;
    logic [4*NDIG-1:0] bcd_d;

    stopwatch_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_lap),
        .press_o(lap_press_s)
    );

    assign lap_accept_s = lap_press_s && (state_q != S_IDLE);

    // Hold toggling; the display snapshot is taken on the entry edge and kept while held.
    always_comb begin
        hold_d = hold_q;
        bcd_d  = cnt_d;
        if (clr_accept_s) begin
            hold_d = 1'b0;
        end else if (lap_accept_s) begin
            hold_d = ~hold_q;
        end else begin
            hold_d = hold_q;
        end
        if (hold_q && hold_d) begin
            bcd_d = bcd_q;
        end else begin
            bcd_d = cnt_d;
        end
    end

    // Display register for the held or live count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            hold_q <= hold_d;
            bcd_q  <= bcd_d;
        end
    end

    assign bcd = bcd_q;
`else
    logic lap_unused_s;
    assign lap_unused_s = btn_lap;
    assign bcd          = cnt_q;
`endif

    assign running = running_q;
    assign tick    = tick_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core (TICK_DIV=4, DEB_CYCLES=3); expected outputs queued, then popped at check points.
module tb_stopwatch_bcd_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic [31:0] bcd;
    logic        running;
    logic        tick;
    logic        ovf;
    logic [11:0] bcd3;
    logic        running3;
    logic        tick3;
    logic        ovf3;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          use3 = 1'b0;
    logic [34:0] exp_q[$];

`ifdef LAP_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    always #5 clk = ~clk;

    stopwatch_bcd_core #(.TICK_DIV(4), .DEB_CYCLES(3), .NDIG(8)) u_dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
        .bcd(bcd), .running(running), .tick(tick), .ovf(ovf)
    );

    stopwatch_bcd_core #(.TICK_DIV(4), .DEB_CYCLES(3), .NDIG(3)) u_dut3 (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
        .bcd(bcd3), .running(running3), .tick(tick3), .ovf(ovf3)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input logic [31:0] b, input logic r, input logic t, input logic o);
        exp_q.push_back({b, r, t, o});
    endtask

    task automatic check(input string tag);
        logic [34:0] obs;
        logic [34:0] expv;
        obs = use3 ? {20'd0, bcd3, running3, tick3, ovf3} : {bcd, running, tick, ovf};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: no queued expectation, observed %h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_err++;
                $error("FAIL %s: observed bcd=%h run=%b tick=%b ovf=%b expected bcd=%h run=%b tick=%b ovf=%b",
                       tag, obs[34:3], obs[2], obs[1], obs[0], expv[34:3], expv[2], expv[1], expv[0]);
            end
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        expect_out(32'h0, 1'b0, 1'b0, 1'b0);
        step(2);
        rst = 1'b0;
        check(tag);
    endtask

    // Button held 6 cycles (action lands on the 6th edge), then 6 idle cycles.
    task automatic press(input bit ss, input bit clr, input bit lap);
        btn_ss = ss;
        btn_clr = clr;
        btn_lap = lap;
        step(6);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        step(6);
    endtask

    initial begin
        int ticks;
        @(negedge clk);

        // Start, debounce latency, first tick, carry into digit1
        do_reset("a_reset");
        btn_ss = 1'b1;
        expect_out(32'h0, 1'b0, 1'b0, 1'b0); step(5);  check("a_debounce");
        expect_out(32'h0, 1'b1, 1'b0, 1'b0); step(1);  check("a_running");
        expect_out(32'h0, 1'b1, 1'b0, 1'b0); step(3);  check("a_pre_tick");
        expect_out(32'h1, 1'b1, 1'b1, 1'b0); step(1);  check("a_first_tick");
        btn_ss = 1'b0;
        expect_out(32'h1, 1'b1, 1'b0, 1'b0); step(1);  check("a_tick_one_cycle");
        expect_out(32'h10, 1'b1, 1'b1, 1'b0); step(35); check("a_carry");

        // Pause at 3, glitch rejection, resume keeps fraction, clr ignored in RUN
        do_reset("b_reset");
        press(1'b1, 1'b0, 1'b0);
        step(2);
        press(1'b1, 1'b0, 1'b0);
        expect_out(32'h3, 1'b0, 1'b0, 1'b0); check("b_pause");
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check_int("b_no_tick_paused", ticks, 0);
        expect_out(32'h3, 1'b0, 1'b0, 1'b0); check("b_paused_hold");
        btn_ss = 1'b1; step(2); btn_ss = 1'b0; step(10);
        expect_out(32'h3, 1'b0, 1'b0, 1'b0); check("b_glitch");
        btn_ss = 1'b1;
        expect_out(32'h3, 1'b1, 1'b0, 1'b0); step(6); check("b_resume");
        expect_out(32'h4, 1'b1, 1'b1, 1'b0); step(2); check("b_resume_tick");
        btn_ss = 1'b0;
        btn_clr = 1'b1;
        expect_out(32'h5, 1'b1, 1'b0, 1'b0); step(6); check("b_clr_in_run");
        expect_out(32'h6, 1'b1, 1'b1, 1'b0); step(2); check("b_clr_run_counting");
        btn_clr = 1'b0;

        // Overflow on the 3-digit instance: 999 -> 000, sticky ovf, clear from PAUSE
        use3 = 1'b1;
        do_reset("c_reset");
        press(1'b1, 1'b0, 1'b0);
        expect_out(32'h998, 1'b1, 1'b0, 1'b0); step(3989); check("c_998");
        expect_out(32'h999, 1'b1, 1'b1, 1'b0); step(1);    check("c_999");
        expect_out(32'h000, 1'b1, 1'b1, 1'b1); step(4);    check("c_wrap_ovf");
        expect_out(32'h001, 1'b1, 1'b1, 1'b1); step(4);    check("c_ovf_sticky");
        press(1'b1, 1'b0, 1'b0);
        expect_out(32'h002, 1'b0, 1'b0, 1'b1); check("c_pause_ovf");
        press(1'b0, 1'b1, 1'b0);
        expect_out(32'h000, 1'b0, 1'b0, 1'b0); check("c_clr_pause");
        btn_ss = 1'b1;
        expect_out(32'h0, 1'b1, 1'b0, 1'b0); step(6); check("c_restart");
        expect_out(32'h0, 1'b1, 1'b0, 1'b0); step(3); check("c_presc_cleared");
        expect_out(32'h1, 1'b1, 1'b1, 1'b0); step(1); check("c_restart_tick");
        btn_ss = 1'b0;
        use3 = 1'b0;

        // Simultaneous ss+clr in RUN and PAUSE, reset mid-RUN
        do_reset("d_reset");
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        expect_out(32'h3, 1'b0, 1'b0, 1'b0); check("d_both_in_run");
        press(1'b1, 1'b1, 1'b0);
        expect_out(32'h0, 1'b0, 1'b0, 1'b0); check("d_both_in_pause");
        press(1'b1, 1'b0, 1'b0);
        expect_out(32'h2, 1'b1, 1'b0, 1'b0); step(3); check("d_run_again");
        rst = 1'b1;
        expect_out(32'h0, 1'b0, 1'b0, 1'b0); step(1); check("d_reset_mid_run");
        rst = 1'b0;

        // Lap hold (frozen display while ticks continue) or no effect without the feature
        do_reset("e_reset");
        btn_ss = 1'b1; step(6); btn_ss = 1'b0;
        step(15);
        btn_lap = 1'b1;
        expect_out(32'h5, 1'b1, 1'b0, 1'b0); step(6); check("e_lap_entry");
        btn_lap = 1'b0;
        expect_out(HOLD ? 32'h5 : 32'h6, 1'b1, 1'b1, 1'b0); step(3); check("e_held_tick");
        step(3);
        btn_lap = 1'b1;
        expect_out(HOLD ? 32'h5 : 32'h7, 1'b1, 1'b1, 1'b0); step(1); check("e_held_tick2");
        expect_out(32'h8, 1'b1, 1'b0, 1'b0); step(5); check("e_lap_release");
        btn_lap = 1'b0;
        step(2);

        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
